dcache_axi_miss_handler: RTL and testbench
==========================================

# dcache_axi_miss_handler

Memory-side responder for the MEM-stage data cache's miss interface. It accepts one outstanding miss request from the cache:
- A read miss becomes an AXI4 INCR burst line fill, and the assembled line is returned to the cache.
- A write miss becomes a single-beat AXI4 write (no-write-allocate).

Either way it then pulses `miss_done` so the cache can clear its miss flag and release its stall. It sits between the data cache and the top-level AXI master port.

## Interface
Parameters:
- `B`, 8, 64-bit words per cache block; power of two, ≥2
- `OFF`, 6, line offset bits (= log2(B*8))

Ports:
- `clk`, in, 1, clock. One clock; all logic on its rising edge.
- `reset`, in, 1, reset. Synchronous, active-high.
- `miss_req`, in, 1, cache miss flag (level), held until `miss_done`
- `miss_addr`, in, 64, faulting byte address
- `miss_write`, in, 1, 1 = store miss, 0 = load miss
- `miss_size`, in, 3, store size: 0=b, 1=h, 2=w, 3=d
- `miss_data`, in, 64, store data, right-aligned (low bytes valid)
- `miss_done`, out, 1, one-cycle completion pulse
- `miss_err`, out, 1, valid with `miss_done`; any non-OKAY resp, or early `rlast`
- `fill_valid`, out, 1, one-cycle pulse, read misses only
- `fill_addr`, out, 64, line-aligned address of the fill
- `fill_data`, out, 64*B, line data; word i at bits [64i+63:64i]
- AR channel: `m_axi_arvalid` out 1; `m_axi_arready` in 1; `m_axi_araddr` out 64; `m_axi_arlen` out 8; `m_axi_arsize` out 3; `m_axi_arburst` out 2
- R channel: `m_axi_rvalid` in 1; `m_axi_rready` out 1; `m_axi_rdata` in 64; `m_axi_rresp` in 2; `m_axi_rlast` in 1
- AW channel: `m_axi_awvalid` out 1; `m_axi_awready` in 1; `m_axi_awaddr` out 64; `m_axi_awlen` out 8; `m_axi_awsize` out 3; `m_axi_awburst` out 2
- W channel: `m_axi_wvalid` out 1; `m_axi_wready` in 1; `m_axi_wdata` out 64; `m_axi_wstrb` out 8; `m_axi_wlast` out 1
- B channel: `m_axi_bvalid` in 1; `m_axi_bready` out 1; `m_axi_bresp` in 2

## Operation
States:
- IDLE: if `miss_req`, latch addr/write/size/data.
  - Read → AR; write → AW_W.
  - Inputs are ignored after the latch.
- AR: `arvalid`=1 with the following fields; move to R on `arready`.
  - `araddr` = addr with [OFF-1:0] cleared
  - `arlen` = B-1, `arsize` = 3, `arburst` = 2'b01
- R: `rready`=1.
  - Each accepted beat writes `rdata` into word `beat_cnt` of the line buffer, then increments `beat_cnt`.
  - On beat B-1 go to RESP.
  - Any `rresp`≠0 sets the error flag.
  - `rlast`=1 before beat B-1 sets the error flag; the burst still runs to B beats.
- AW_W: `awvalid`/`wvalid` asserted together; each drops independently once accepted. Go to BR when both are accepted.
  - `awaddr` = addr with [2:0] cleared; `awlen`=0, `awsize`=3, `awburst`=2'b01
  - `wdata` = `miss_data` << 8*addr[2:0]
  - `wstrb` = ((1<<(1<<size))-1) << addr[2:0]
  - `wlast`=1
- BR: `bready`=1; on `bvalid`, the error flag is set to (`bresp`≠0); go to RESP.
- RESP: one cycle.
  - `miss_done`=1, `miss_err` = error flag.
  - `fill_valid`=1 only for a read; `fill_addr`/`fill_data` stable this cycle.
  - Go to HOLD.
- HOLD: one cycle; `miss_req` ignored (cache drops it this cycle); go to IDLE.

Rules:
- Error flag and `beat_cnt` clear on entry from IDLE.
- Store misaligned beyond its natural size: behaviour is undefined; the cache guarantees alignment.
- Reset values: state IDLE, every output 0, `fill_data` 0, `beat_cnt` 0.
- Reset mid-transaction abandons AXI state. The interconnect is reset together with this block.

## Timing
- Miss seen in IDLE at cycle N → AR/AW/W valid at N+1.
- Read with zero-wait slave: R beats N+2..N+B+1; RESP N+B+2; HOLD N+B+3; IDLE N+B+4.
- Write with zero-wait slave: BR N+2, `bvalid` N+2 → RESP N+3.
- VALID never depends combinationally on READY; outputs hold stable until the handshake.
- R stall (`rvalid`=0) just waits; no timeout.

## Test plan
1. Read miss, addr 0x1000_0048, B=8, zero-wait slave returning words 0x11..0x18.
   - `araddr`=0x1000_0040, `arlen`=7.
   - `fill_data` word i = 0x11+i.
   - `fill_valid` and `miss_done` both at N+10, `miss_err`=0.
2. Store byte 0xAB at 0x2003.
   - `awaddr`=0x2000, `wstrb`=0x08, `wdata`=0x0000_0000_AB00_0000.
   - No `fill_valid`; `miss_done` after `bvalid`.
3. Store word at 0x2004 with `awready` delayed 3 cycles, `wready` immediate.
   - `wvalid` drops after 1 cycle; `awvalid` held 4 cycles.
   - Exactly one `miss_done`.
4. Read with random R gaps, `rresp`=2'b10 on beat 3.
   - All 8 words captured.
   - `miss_err`=1 with `miss_done`.
5. `reset` asserted during R beat 4.
   - Next cycle all outputs 0 and state IDLE.
   - A fresh read miss then completes normally.
6. `miss_req` held high through HOLD.
   - No second transaction starts until IDLE.
   - A new request in IDLE produces `arvalid` the following cycle.

Source files
------------

// File: rtl/dcache_axi_miss_handler.sv
// dcache_axi_miss_handler
//   Services one outstanding data-cache miss at a time over an AXI4 master port.
//   A load miss issues an INCR line-fill burst and returns the assembled line.
//   A store miss issues a single-beat write; there is no write-allocate.
//   Both finish with a one-cycle miss_done pulse, then one HOLD cycle so the
//   cache can drop miss_req before another request is accepted.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   miss_*            : miss request from the cache (level, held until miss_done)
//   miss_done/err     : completion pulse and error status
//   fill_*            : line fill returned to the cache (load misses only)
//   m_axi_ar*/r*      : AXI4 read address / read data channels
//   m_axi_aw*/w*/b*   : AXI4 write address / write data / write response channels
module dcache_axi_miss_handler #(
  parameter int B   = 8,
  parameter int OFF = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              miss_req,
  input  logic [63:0]       miss_addr,
  input  logic              miss_write,
  input  logic [2:0]        miss_size,
  input  logic [63:0]       miss_data,
  output logic              miss_done,
  output logic              miss_err,
  output logic              fill_valid,
  output logic [63:0]       fill_addr,
  output logic [64*B-1:0]   fill_data,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  output logic [63:0]       m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  input  logic [63:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [63:0]       m_axi_awaddr,
  output logic [7:0]        m_axi_awlen,
  output logic [2:0]        m_axi_awsize,
  output logic [1:0]        m_axi_awburst,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  output logic [63:0]       m_axi_wdata,
  output logic [7:0]        m_axi_wstrb,
  output logic              m_axi_wlast,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  input  logic [1:0]        m_axi_bresp
);

  localparam int BW = $clog2(B);

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_AW_W, S_BR, S_RESP, S_HOLD
  } state_t;

  state_t          state_reg, state_next;
  logic [63:0]     addr_reg;
  logic            write_reg;
  logic [2:0]      size_reg;
  logic [63:0]     data_reg;
  logic            err_reg;
  logic [BW-1:0]   beat_cnt_reg;
  logic            aw_done_reg;
  logic            w_done_reg;
  logic [63:0]     line_reg [B];

  logic            r_fire;
  logic            last_beat;
  logic            aw_ok;
  logic            w_ok;
  logic [2:0]      byte_off;
  logic [3:0]      store_bytes;
  logic [15:0]     strb_wide;

  assign r_fire    = (state_reg == S_R) && m_axi_rvalid;
  assign last_beat = (beat_cnt_reg == BW'(B - 1));
  // A channel counts as done if it was accepted earlier or is being accepted now.
  assign aw_ok     = aw_done_reg | m_axi_awready;
  assign w_ok      = w_done_reg  | m_axi_wready;

  // Store lane placement: data is right-aligned, so shift it up to its byte lane.
  assign byte_off    = addr_reg[2:0];
  assign store_bytes = 4'd1 << size_reg;
  assign strb_wide   = ((16'd1 << store_bytes) - 16'd1) << byte_off;

  assign fill_addr = {addr_reg[63:OFF], {OFF{1'b0}}};

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (miss_req) state_next = miss_write ? S_AW_W : S_AR;
      S_AR:    if (m_axi_arready) state_next = S_R;
      S_R:     if (r_fire && last_beat) state_next = S_RESP;
      S_AW_W:  if (aw_ok && w_ok) state_next = S_BR;
      S_BR:    if (m_axi_bvalid) state_next = S_RESP;
      S_RESP:  state_next = S_HOLD;
      S_HOLD:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------- outputs ----------------
  // Payload fields are only driven in their channel's state so every output
  // reads zero while idle and out of reset.
  always_comb begin
    miss_done     = 1'b0;
    miss_err      = 1'b0;
    fill_valid    = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_araddr  = 64'd0;
    m_axi_arlen   = 8'd0;
    m_axi_arsize  = 3'd0;
    m_axi_arburst = 2'd0;
    m_axi_rready  = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_awaddr  = 64'd0;
    m_axi_awlen   = 8'd0;
    m_axi_awsize  = 3'd0;
    m_axi_awburst = 2'd0;
    m_axi_wvalid  = 1'b0;
    m_axi_wdata   = 64'd0;
    m_axi_wstrb   = 8'd0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    case (state_reg)
      S_AR: begin
        m_axi_arvalid = 1'b1;
        m_axi_araddr  = {addr_reg[63:OFF], {OFF{1'b0}}};
        m_axi_arlen   = 8'(B - 1);
        m_axi_arsize  = 3'd3;
        m_axi_arburst = 2'b01;
      end
      S_R: begin
        m_axi_rready = 1'b1;
      end
      S_AW_W: begin
        m_axi_awvalid = ~aw_done_reg;
        m_axi_awaddr  = {addr_reg[63:3], 3'b000};
        m_axi_awsize  = 3'd3;
        m_axi_awburst = 2'b01;
        m_axi_wvalid  = ~w_done_reg;
        m_axi_wdata   = data_reg << {byte_off, 3'b000};
        m_axi_wstrb   = strb_wide[7:0];
        m_axi_wlast   = 1'b1;
      end
      S_BR: begin
        m_axi_bready = 1'b1;
      end
      S_RESP: begin
        miss_done  = 1'b1;
        miss_err   = err_reg;
        fill_valid = ~write_reg;
      end
      default: ;
    endcase
  end

  // ---------------- request latch, counters, status ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg     <= 64'd0;
      write_reg    <= 1'b0;
      size_reg     <= 3'd0;
      data_reg     <= 64'd0;
      err_reg      <= 1'b0;
      beat_cnt_reg <= '0;
      aw_done_reg  <= 1'b0;
      w_done_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (miss_req) begin
            addr_reg     <= miss_addr;
            write_reg    <= miss_write;
            size_reg     <= miss_size;
            data_reg     <= miss_data;
            err_reg      <= 1'b0;
            beat_cnt_reg <= '0;
            aw_done_reg  <= 1'b0;
            w_done_reg   <= 1'b0;
          end
        end
        S_R: begin
          if (r_fire) begin
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
            // An early rlast is flagged but the burst is still counted to B beats.
            if ((m_axi_rresp != 2'b00) || (m_axi_rlast && !last_beat)) begin
              err_reg <= 1'b1;
            end
          end
        end
        S_AW_W: begin
          aw_done_reg <= aw_ok;
          w_done_reg  <= w_ok;
        end
        S_BR: begin
          if (m_axi_bvalid) begin
            err_reg <= (m_axi_bresp != 2'b00);
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- line buffer ----------------
  // Plain registers rather than RAM: the whole line is presented in parallel.
  generate
    for (genvar gi = 0; gi < B; gi++) begin : g_line
      always_ff @(posedge clk) begin
        if (reset) begin
          line_reg[gi] <= 64'd0;
        end else if (r_fire && (beat_cnt_reg == BW'(gi))) begin
          line_reg[gi] <= m_axi_rdata;
        end
      end
      assign fill_data[64*gi +: 64] = line_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_dcache_axi_miss_handler.sv
module tb_dcache_axi_miss_handler;

  localparam int B   = 8;
  localparam int OFF = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              miss_req;
  logic [63:0]       miss_addr;
  logic              miss_write;
  logic [2:0]        miss_size;
  logic [63:0]       miss_data;
  logic              miss_done;
  logic              miss_err;
  logic              fill_valid;
  logic [63:0]       fill_addr;
  logic [64*B-1:0]   fill_data;
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [63:0]       m_axi_araddr;
  logic [7:0]        m_axi_arlen;
  logic [2:0]        m_axi_arsize;
  logic [1:0]        m_axi_arburst;
  logic              m_axi_rvalid;
  logic              m_axi_rready;
  logic [63:0]       m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rlast;
  logic              m_axi_awvalid;
  logic              m_axi_awready;
  logic [63:0]       m_axi_awaddr;
  logic [7:0]        m_axi_awlen;
  logic [2:0]        m_axi_awsize;
  logic [1:0]        m_axi_awburst;
  logic              m_axi_wvalid;
  logic              m_axi_wready;
  logic [63:0]       m_axi_wdata;
  logic [7:0]        m_axi_wstrb;
  logic              m_axi_wlast;
  logic              m_axi_bvalid;
  logic              m_axi_bready;
  logic [1:0]        m_axi_bresp;

  int total = 0;
  int bad   = 0;

  dcache_axi_miss_handler #(.B(B), .OFF(OFF)) dut (
    .clk           (clk),
    .reset         (reset),
    .miss_req      (miss_req),
    .miss_addr     (miss_addr),
    .miss_write    (miss_write),
    .miss_size     (miss_size),
    .miss_data     (miss_data),
    .miss_done     (miss_done),
    .miss_err      (miss_err),
    .fill_valid    (fill_valid),
    .fill_addr     (fill_addr),
    .fill_data     (fill_data),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awlen   (m_axi_awlen),
    .m_axi_awsize  (m_axi_awsize),
    .m_axi_awburst (m_axi_awburst),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wlast   (m_axi_wlast),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_bresp   (m_axi_bresp)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] word_of(input int i);
    logic [64*B-1:0] fd;
    fd = fill_data;
    return fd[64*i +: 64];
  endfunction

  // Load miss against a slave whose beat i carries base+i. With gaps set,
  // beat i is preceded by (i*5)%3 idle cycles. Returns in the RESP cycle
  // with miss_req still high.
  task automatic run_read(input string tag, input logic [63:0] addr, input logic [63:0] exp_araddr,
                          input logic [63:0] base, input bit gaps, input int bad_beat,
                          input int early_beat, input logic exp_err);
    miss_req   = 1'b1;
    miss_addr  = addr;
    miss_write = 1'b0;
    step();
    chk({tag, ":arvalid"}, 64'(m_axi_arvalid), 64'd1);
    chk({tag, ":araddr"},  m_axi_araddr, exp_araddr);
    chk({tag, ":arlen"},   64'(m_axi_arlen), 64'd7);
    chk({tag, ":arsize"},  64'(m_axi_arsize), 64'd3);
    chk({tag, ":arburst"}, 64'(m_axi_arburst), 64'd1);
    m_axi_arready = 1'b1;
    step();
    m_axi_arready = 1'b0;
    chk({tag, ":arvalid_drop"}, 64'(m_axi_arvalid), 64'd0);
    chk({tag, ":rready"},       64'(m_axi_rready), 64'd1);
    for (int i = 0; i < B; i++) begin
      if (gaps) begin
        for (int g = 0; g < (i * 5) % 3; g++) begin
          m_axi_rvalid = 1'b0;
          step();
          chk({tag, ":stall_rready"}, 64'(m_axi_rready), 64'd1);
        end
      end
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = base + 64'(i);
      m_axi_rresp  = (i == bad_beat) ? 2'b10 : 2'b00;
      m_axi_rlast  = (i == B - 1) || (i == early_beat);
      if (i == B - 1) chk({tag, ":no_early_done"}, 64'(miss_done), 64'd0);
      step();
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    m_axi_rresp  = 2'b00;
    chk({tag, ":miss_done"},  64'(miss_done), 64'd1);
    chk({tag, ":fill_valid"}, 64'(fill_valid), 64'd1);
    chk({tag, ":miss_err"},   64'(miss_err), 64'(exp_err));
    chk({tag, ":fill_addr"},  fill_addr, exp_araddr);
    for (int i = 0; i < B; i++) begin
      chk($sformatf("%s:word%0d", tag, i), word_of(i), base + 64'(i));
    end
  endtask

  // From RESP: cache drops miss_req, pass HOLD, back in IDLE.
  task automatic release_req();
    miss_req = 1'b0;
    step();
    step();
  endtask

  // Store miss; awready is withheld for aw_delay cycles, wready is immediate.
  task automatic run_write(input string tag, input logic [63:0] addr, input logic [2:0] size,
                           input logic [63:0] data, input logic [63:0] exp_awaddr,
                           input logic [7:0] exp_strb, input logic [63:0] exp_wdata,
                           input int aw_delay, input logic [1:0] bresp, input logic exp_err);
    int ndone;
    int done_at;
    miss_req   = 1'b1;
    miss_addr  = addr;
    miss_write = 1'b1;
    miss_size  = size;
    miss_data  = data;
    step();
    chk({tag, ":awvalid"}, 64'(m_axi_awvalid), 64'd1);
    chk({tag, ":wvalid"},  64'(m_axi_wvalid), 64'd1);
    chk({tag, ":awaddr"},  m_axi_awaddr, exp_awaddr);
    chk({tag, ":awlen"},   64'(m_axi_awlen), 64'd0);
    chk({tag, ":awsize"},  64'(m_axi_awsize), 64'd3);
    chk({tag, ":wstrb"},   64'(m_axi_wstrb), 64'(exp_strb));
    chk({tag, ":wdata"},   m_axi_wdata, exp_wdata);
    chk({tag, ":wlast"},   64'(m_axi_wlast), 64'd1);
    m_axi_wready  = 1'b1;
    m_axi_awready = (aw_delay == 0);
    for (int c = 0; c < aw_delay; c++) begin
      step();
      m_axi_wready = 1'b0;
      chk($sformatf("%s:wvalid_dropped%0d", tag, c), 64'(m_axi_wvalid), 64'd0);
      chk($sformatf("%s:awvalid_held%0d", tag, c), 64'(m_axi_awvalid), 64'd1);
      if (c == aw_delay - 1) m_axi_awready = 1'b1;
    end
    step();
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    chk({tag, ":bready"},       64'(m_axi_bready), 64'd1);
    chk({tag, ":awvalid_drop"}, 64'(m_axi_awvalid), 64'd0);
    chk({tag, ":wvalid_drop"},  64'(m_axi_wvalid), 64'd0);
    m_axi_bvalid = 1'b1;
    m_axi_bresp  = bresp;
    ndone   = 0;
    done_at = -1;
    for (int c = 0; c < 5; c++) begin
      step();
      m_axi_bvalid = 1'b0;
      m_axi_bresp  = 2'b00;
      if (miss_done) begin
        ndone++;
        if (done_at < 0) done_at = c;
        chk({tag, ":miss_err"},   64'(miss_err), 64'(exp_err));
        chk({tag, ":fill_valid"}, 64'(fill_valid), 64'd0);
        miss_req = 1'b0;
      end
    end
    chk({tag, ":done_count"}, 64'(ndone), 64'd1);
    chk({tag, ":done_at"},    64'(done_at), 64'd0);
  endtask

  initial begin
    reset         = 1'b1;
    miss_req      = 1'b0;
    miss_addr     = 64'd0;
    miss_write    = 1'b0;
    miss_size     = 3'd0;
    miss_data     = 64'd0;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rdata   = 64'd0;
    m_axi_rresp   = 2'b00;
    m_axi_rlast   = 1'b0;
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bvalid  = 1'b0;
    m_axi_bresp   = 2'b00;
    step();
    step();

    // Reset state
    chk("rst:miss_done",  64'(miss_done), 64'd0);
    chk("rst:arvalid",    64'(m_axi_arvalid), 64'd0);
    chk("rst:arlen",      64'(m_axi_arlen), 64'd0);
    chk("rst:awvalid",    64'(m_axi_awvalid), 64'd0);
    chk("rst:wvalid",     64'(m_axi_wvalid), 64'd0);
    chk("rst:wstrb",      64'(m_axi_wstrb), 64'd0);
    chk("rst:rready",     64'(m_axi_rready), 64'd0);
    chk("rst:bready",     64'(m_axi_bready), 64'd0);
    chk("rst:fill_valid", 64'(fill_valid), 64'd0);
    chk("rst:fill_addr",  fill_addr, 64'd0);
    chk("rst:word0",      word_of(0), 64'd0);
    reset = 1'b0;
    step();
    chk("idle:arvalid", 64'(m_axi_arvalid), 64'd0);

    // 1: zero-wait line fill
    run_read("rd1", 64'h1000_0048, 64'h1000_0040, 64'h11, 1'b0, -1, -1, 1'b0);
    $display("rd1 line fill araddr=0x%0h err=%0d", m_axi_araddr, miss_err);
    release_req();

    // 2: store byte
    run_write("wr_b", 64'h2003, 3'd0, 64'hAB, 64'h2000, 8'h08, 64'h0000_0000_AB00_0000, 0, 2'b00, 1'b0);
    $display("wr_b store byte at 0x2003 complete");
    // 3: store word, awready delayed 3 cycles
    run_write("wr_w", 64'h2004, 3'd2, 64'hDEAD_BEEF, 64'h2000, 8'hF0, 64'hDEAD_BEEF_0000_0000, 3, 2'b00, 1'b0);
    $display("wr_w store word at 0x2004 complete");
    // store doubleword with SLVERR response
    run_write("wr_d", 64'h2008, 3'd3, 64'h0123_4567_89AB_CDEF, 64'h2008, 8'hFF, 64'h0123_4567_89AB_CDEF, 0, 2'b10, 1'b1);
    $display("wr_d store dword with error response complete");

    // 4: R gaps, error response on beat 3
    run_read("rd_gap", 64'h3000_0010, 64'h3000_0000, 64'hA0, 1'b1, 3, -1, 1'b1);
    $display("rd_gap line fill with stalls err=%0d", miss_err);
    release_req();

    // 5: reset during beat 4
    miss_req   = 1'b1;
    miss_addr  = 64'h4000_0000;
    miss_write = 1'b0;
    step();
    m_axi_arready = 1'b1;
    step();
    m_axi_arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = 64'h99 + 64'(i);
      step();
    end
    m_axi_rdata = 64'h9D;
    reset       = 1'b1;
    miss_req    = 1'b0;
    step();
    m_axi_rvalid = 1'b0;
    chk("rstmid:rready",     64'(m_axi_rready), 64'd0);
    chk("rstmid:arvalid",    64'(m_axi_arvalid), 64'd0);
    chk("rstmid:miss_done",  64'(miss_done), 64'd0);
    chk("rstmid:fill_valid", 64'(fill_valid), 64'd0);
    chk("rstmid:fill_addr",  fill_addr, 64'd0);
    chk("rstmid:word0",      word_of(0), 64'd0);
    reset = 1'b0;
    step();
    run_read("rd_post", 64'h4000_0078, 64'h4000_0040, 64'h40, 1'b0, -1, -1, 1'b0);
    $display("rd_post line fill after reset err=%0d", miss_err);
    release_req();

    // 6: miss_req held through HOLD, then an early-rlast read
    run_read("rd_hold", 64'h5000_0000, 64'h5000_0000, 64'h50, 1'b0, -1, -1, 1'b0);
    step();
    chk("hold:arvalid",   64'(m_axi_arvalid), 64'd0);
    chk("hold:miss_done", 64'(miss_done), 64'd0);
    step();
    chk("idle2:arvalid",  64'(m_axi_arvalid), 64'd0);
    run_read("rd_early", 64'h5000_00C0, 64'h5000_00C0, 64'h60, 1'b0, -1, 2, 1'b1);
    $display("rd_early line fill with early rlast err=%0d", miss_err);
    release_req();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
